// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: credit-based reads into a 2-entry skid buffer,
// valid/ready output with packet framing. Optional stats: FIFO_RD_STATS_EN.
module fifo_rd_ctrl #(
  parameter int DATA_W  = 128,
  parameter int PKT_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_empty,
  output logic              o_rden,
  input  logic [DATA_W-1:0] i_rddata,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [31:0]       o_word_cnt,
  output logic [31:0]       o_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t            r_state;
  logic              r_inflight;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;
  logic [15:0]       r_beat;

  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic [1:0] w_cnt_nxt;

  assign w_pop     = (r_cnt != 2'd0) & i_ready;
  assign w_push    = r_inflight;
  // Occupancy after this cycle's pop, counting the word still in flight.
  assign w_occ     = {1'b0, r_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  assign o_rden  = (r_state == S_RUN) & ~i_empty & (w_occ < 3'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_d0;
  assign o_last  = o_valid & (r_beat == LAST_BEAT);
  assign o_busy  = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_en) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!i_en) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (i_en)
            r_state <= S_RUN;
          else if (w_cnt_nxt == 2'd0)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
      r_d0       <= '0;
      r_d1       <= '0;
    end else begin
      r_inflight <= o_rden;
      r_cnt      <= w_cnt_nxt;
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_rddata;
          else               r_d1 <= i_rddata;
        end
        2'b01: begin
          r_d0 <= r_d1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= i_rddata;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_rddata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= 16'd0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST_BEAT) ? 16'd0 : r_beat + 16'd1;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [31:0] r_word_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt  <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_pop && r_word_cnt != 32'hFFFF_FFFF)
        r_word_cnt <= r_word_cnt + 32'd1;
      if (o_valid && !i_ready && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_word_cnt  = r_word_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_word_cnt  = 32'd0;
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model with registered read data,
// scoreboard queue filled by stimulus and drained by a negedge monitor.
module tb_fifo_rd_ctrl;

  localparam int DW = 128;
  localparam int PL = 16;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          ready = 1'b1;
  logic          empty;
  logic          rden;
  logic [DW-1:0] rddata = '0;
  logic          valid;
  logic [DW-1:0] data;
  logic          last;
  logic          busy;
  logic [31:0]   wcnt;
  logic [31:0]   scnt;

  logic          u1_rden;
  logic          u1_valid;
  logic [DW-1:0] u1_data;
  logic          u1_last;
  logic          u1_busy;
  logic [31:0]   u1_wcnt;
  logic [31:0]   u1_scnt;
  logic [DW-1:0] u1_rddata;

  logic [DW-1:0] mem [0:255];
  int rp = 0;
  int wp = 0;
  int cyc = 0;
  int exp_idx = 0;
  exp_t exq [$];

  int tests = 0;
  int errors = 0;
  int pop_cyc = -1;
  int drain_rd = 0;
  bit draining = 1'b0;
  bit hold_v = 1'b0;
  logic [DW-1:0] hold_d;

  always #5 clk = ~clk;

  assign empty     = (rp == wp);
  assign u1_rddata = {96'd0, 32'(cyc)};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rden) begin
      rddata <= mem[rp[7:0]];
      rp     <= rp + 1;
    end
  end

  fifo_rd_ctrl #(.DATA_W(DW), .PKT_LEN(PL)) u_dut (
    .clk(clk), .rst(rst), .i_en(en), .i_empty(empty),
    .o_rden(rden), .i_rddata(rddata), .o_valid(valid),
    .o_data(data), .o_last(last), .i_ready(ready),
    .o_busy(busy), .o_word_cnt(wcnt), .o_stall_cnt(scnt)
  );

  fifo_rd_ctrl #(.DATA_W(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_en(en), .i_empty(1'b0),
    .o_rden(u1_rden), .i_rddata(u1_rddata), .o_valid(u1_valid),
    .o_data(u1_data), .o_last(u1_last), .i_ready(1'b1),
    .o_busy(u1_busy), .o_word_cnt(u1_wcnt), .o_stall_cnt(u1_scnt)
  );

  task automatic chk(input string n, input logic [DW-1:0] a,
                     input logic [DW-1:0] e);
    tests++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      mem[wp[7:0]] = DW'(base + i);
      e.d = DW'(base + i);
      e.l = ((exp_idx % PL) == PL - 1);
      exq.push_back(e);
      exp_idx++;
      wp++;
    end
  endtask

  task automatic wait_empty(input string n, input int max);
    int k = 0;
    while (exq.size() != 0 && k < max) begin
      tick();
      k++;
    end
    chk(n, DW'(exq.size()), DW'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (valid && ready) begin
        if (exq.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL spurious: got %0h expected none", data);
        end else begin
          e = exq.pop_front();
          chk("data", data, e.d);
          chk("last", DW'(last), DW'(e.l));
        end
        pop_cyc = cyc;
      end
      if (valid && !ready && hold_v)
        chk("hold", data, hold_d);
      hold_v = valid && !ready;
      hold_d = data;
      if (draining && rden) drain_rd++;
      if (u1_valid) chk("last1", DW'(u1_last), DW'(1));
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    int rd_c;
    int v_c;
    int bad;

    #1 rst = 1'b1;
    #1;
    chk("rst_valid", DW'(valid), DW'(0));
    chk("rst_last", DW'(last), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_data", data, DW'(0));
    chk("rst_rden", DW'(rden), DW'(0));
    chk("rst_wcnt", DW'(wcnt), DW'(0));
    chk("rst_scnt", DW'(scnt), DW'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // streaming 0..39
    load(40, 0);
    en = 1'b1;
    rd_c = -1;
    v_c = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rden && rd_c < 0) rd_c = i;
      if (valid) begin
        v_c = i;
        break;
      end
    end
    chk("first_rden", DW'(rd_c), DW'(0));
    chk("latency", DW'(v_c - rd_c), DW'(2));
    for (int i = 0; i < 40; i++) tick();
    chk("stream_done", DW'(exq.size()), DW'(0));
    chk("stream_idle", DW'(valid), DW'(0));

    // backpressure
    load(20, 100);
    for (int i = 0; i < 5; i++) tick();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_rden", DW'(rden), DW'(0));
    chk("bp_valid", DW'(valid), DW'(1));
    ready = 1'b1;
    wait_empty("bp_done", 100);
`ifdef FIFO_RD_STATS_EN
    chk("stall_cnt", DW'(scnt), DW'(10));
    chk("word_cnt", DW'(wcnt), DW'(60));
`else
    chk("stall_cnt", DW'(scnt), DW'(0));
    chk("word_cnt", DW'(wcnt), DW'(0));
`endif

    // drain with count=1 and one word in flight
    ready = 1'b0;
    load(10, 200);
    tick();
    tick();
    en = 1'b0;
    draining = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ready = 1'b1;
    bad = 0;
    while (busy && bad < 20) begin
      tick();
      bad++;
    end
    chk("busy_fall", DW'(cyc), DW'(pop_cyc + 1));
    chk("drain_left", DW'(exq.size()), DW'(8));
    chk("drain_rden", DW'(drain_rd), DW'(0));
    draining = 1'b0;
    en = 1'b1;
    wait_empty("resume_done", 100);
    for (int i = 0; i < 3; i++) tick();

    // empty FIFO while running
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rden || valid) bad++;
    end
    chk("empty_idle", DW'(bad), DW'(0));
    load(5, 300);
    wait_empty("empty_resume", 50);
    for (int i = 0; i < 5; i++) tick();

    // reset with a full buffer
    ready = 1'b0;
    load(6, 400);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_full", DW'(valid & ~rden), DW'(1));
    rst = 1'b1;
    en = 1'b0;
    #1;
    chk("mid_valid", DW'(valid), DW'(0));
    chk("mid_last", DW'(last), DW'(0));
    chk("mid_busy", DW'(busy), DW'(0));
    chk("mid_data", data, DW'(0));
    chk("mid_rden", DW'(rden), DW'(0));
    chk("mid_scnt", DW'(scnt), DW'(0));
    chk("mid_wcnt", DW'(wcnt), DW'(0));
    exq.delete();
    wp = rp;
    exp_idx = 0;
    tick();
    tick();
    rst = 1'b0;
    ready = 1'b1;
    load(3, 500);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rden || busy) bad++;
    end
    chk("post_rst_idle", DW'(bad), DW'(0));
    chk("post_rst_left", DW'(exq.size()), DW'(3));
    en = 1'b1;
    wait_empty("post_rst_done", 50);
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
